lcd_test_pattern_gen: RTL
=========================

LCD_TEST_PATTERN_GEN -- requirements
Module: lcd_test_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 480, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 272, visible lines per frame.
REQ-003 Parameter TILE_LOG2, default 3, log2 of the square tile edge (8 px).
REQ-004 Parameter BAR_LOG2, default 6, log2 of colour-bar width (64 px).
REQ-005 Parameter CURSOR_DIV, default 1, range 1..255; number of frame starts per cursor step.
REQ-006 Parameters RW/GW/BW, defaults 5/6/5, colour channel widths.
REQ-007 in_clk  input  1  pixel-rate clock; the only clock.
REQ-008 in_rst  input  1  synchronous, active-high reset.
REQ-009 in_pixelx / in_pixely  input  10 each  current pixel coordinate from the timing generator.
REQ-010 in_de  input  1  high while the coordinate is inside the visible area.
REQ-011 in_frame_start  input  1  single-cycle strobe, once per frame, in in_clk domain.
REQ-012 in_mode  input  2  pattern select: 0 checker+cursor, 1 colour bars, 2 gradient, 3 tile grid.
REQ-013 out_r / out_g / out_b  output  RW/GW/BW  pixel colour.
REQ-014 out_tile_x / out_tile_y  output  7 each  current cursor tile.
REQ-015 out_frame_count  output  16  frame-start count.

Function
REQ-016 TILES_X = ceil(H_ACTIVE/2^TILE_LOG2) and TILES_Y = ceil(V_ACTIVE/2^TILE_LOG2) shall be computed at elaboration time (60 and 34 at defaults).
REQ-017 The frame counter shall increment by 1 on each in_frame_start and wrap 0xFFFF->0.
REQ-018 A prescaler shall count frame starts 0..CURSOR_DIV-1; the cursor shall step on the frame start at which the prescaler equals CURSOR_DIV-1, and the prescaler shall return to 0 on that same frame start.
REQ-019 Cursor step: tile_x+1; at tile_x=TILES_X-1, tile_x->0 and tile_y+1; at (TILES_X-1, TILES_Y-1), the cursor shall go to (0,0); tile_y shall never exceed TILES_Y-1.
REQ-020 in_mode shall be latched only on in_frame_start; changes mid-frame shall take effect in the next frame.
REQ-021 Colour outputs shall be registered with exactly 1 in_clk cycle of latency from in_pixelx/in_pixely/in_de.
REQ-022 When in_de=0, all colour outputs shall be 0 one cycle later.
REQ-023 Mode 0: r=half-scale (MSB 0, other bits 1) if pixelx[TILE_LOG2]^pixely[TILE_LOG2], else 0; g likewise using bit TILE_LOG2+1; b likewise using bit TILE_LOG2+2; a pixel inside the cursor tile shall instead have r=all ones, with g and b unchanged.
REQ-024 Mode 1: bar = pixelx>>BAR_LOG2, saturated at 7; colours for bars 0..7 shall be white, yellow, cyan, green, magenta, red, blue, black; each channel all ones or 0.
REQ-025 Mode 2: r = pixelx[RW+2:3], g = pixely[GW+1:2], b = (pixelx+pixely)[BW+3:4], each truncated to the channel width.
REQ-026 Mode 3: white (all ones) where pixelx or pixely mod 2^TILE_LOG2 is 0, or where the pixel is on the last line or last column of the visible area; black elsewhere.
REQ-027 Coordinates at or beyond H_ACTIVE/V_ACTIVE while in_de=1 shall produce 0 on all channels.
REQ-028 Cursor tile test shall use comparisons against tile_x<<TILE_LOG2 and (tile_x+1)<<TILE_LOG2 (likewise for y), with no multipliers.

Reset
REQ-029 While in_rst=1 at a clock edge: colour outputs 0, tile 0/0, frame_count 0, prescaler 0, latched mode 0; in_frame_start shall be ignored.
REQ-030 Reset asserted mid-frame shall take effect on the next edge; the first frame start after release shall apply its normal count and step rules.

Verification
REQ-031 Reset, in_de=1, mode 0, (x,y)=(0,0) -> next cycle r=5'b11111 (cursor), g=0, b=0.
REQ-032 CURSOR_DIV=1, 59 frame starts -> tile (59,0); 1 more -> (0,1); 2040 total -> (0,0); frame_count=2040.
REQ-033 CURSOR_DIV=3, 3 frame starts -> tile (1,0) after the 3rd strobe only.
REQ-034 Mode 1 latched, x=64,y=10 -> yellow (r=31,g=63,b=0); x=479 -> black; in_de=0 -> all 0.
REQ-035 Drive in_mode=3 mid-frame -> output unchanged until the next in_frame_start; then x=8 -> white, x=9,y=9 -> black.
REQ-036 Assert in_rst for 1 cycle after 100 frames -> tile 0/0, frame_count 0, outputs 0.

Source files
------------

// File: rtl/lcd_test_pattern_gen_if.sv
// lcd_test_pattern_gen_if: pixel-timing inputs and colour/cursor/frame outputs of the pattern generator
// master drives in_* (coordinate, de, frame strobe, mode) and observes out_*; slave is the generator
interface lcd_test_pattern_gen_if #(
  parameter int RW = 5,
  parameter int GW = 6,
  parameter int BW = 5
);
  logic [9:0]    in_pixelx;
  logic [9:0]    in_pixely;
  logic          in_de;
  logic          in_frame_start;
  logic [1:0]    in_mode;
  logic [RW-1:0] out_r;
  logic [GW-1:0] out_g;
  logic [BW-1:0] out_b;
  logic [6:0]    out_tile_x;
  logic [6:0]    out_tile_y;
  logic [15:0]   out_frame_count;
  modport master (
    output in_pixelx, in_pixely, in_de, in_frame_start, in_mode,
    input  out_r, out_g, out_b, out_tile_x, out_tile_y, out_frame_count
  );
  modport slave (
    input  in_pixelx, in_pixely, in_de, in_frame_start, in_mode,
    output out_r, out_g, out_b, out_tile_x, out_tile_y, out_frame_count
  );
endinterface

// File: rtl/lcd_test_pattern_gen.sv
// lcd_test_pattern_gen: LCD test-pattern source (checker+cursor, colour bars, gradient, tile grid)
// in_clk: pixel clock; in_rst: synchronous active-high reset
// bus (slave): in_pixelx/in_pixely/in_de/in_frame_start/in_mode in; out_r/g/b registered colour,
//              out_tile_x/out_tile_y cursor tile, out_frame_count frame-start counter out
module lcd_test_pattern_gen #(
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int TILE_LOG2  = 3,
  parameter int BAR_LOG2   = 6,
  parameter int CURSOR_DIV = 1,
  parameter int RW         = 5,
  parameter int GW         = 6,
  parameter int BW         = 5
) (
  input logic in_clk,
  input logic in_rst,
  lcd_test_pattern_gen_if.slave bus
);
  localparam int TILE    = 1 << TILE_LOG2;
  localparam int TILES_X = (H_ACTIVE + TILE - 1) >> TILE_LOG2;
  localparam int TILES_Y = (V_ACTIVE + TILE - 1) >> TILE_LOG2;
  localparam logic [9:0]    T_MASK = 10'(TILE - 1);
  localparam logic [RW-1:0] R_HALF = {1'b0, {(RW-1){1'b1}}};
  localparam logic [GW-1:0] G_HALF = {1'b0, {(GW-1){1'b1}}};
  localparam logic [BW-1:0] B_HALF = {1'b0, {(BW-1){1'b1}}};
  logic [1:0]    r_mode;
  logic [7:0]    r_presc;
  logic [6:0]    r_tile_x;
  logic [6:0]    r_tile_y;
  logic [15:0]   r_frame_count;
  logic [RW-1:0] r_r;
  logic [GW-1:0] r_g;
  logic [BW-1:0] r_b;
  logic [9:0]    w_x;
  logic [9:0]    w_y;
  logic [16:0]   w_cx0;
  logic [16:0]   w_cx1;
  logic [16:0]   w_cy0;
  logic [16:0]   w_cy1;
  logic          w_cursor;
  logic          w_in_range;
  logic          w_grid;
  logic          w_step;
  logic          w_last_x;
  logic [9:0]    w_bar_raw;
  logic [2:0]    w_bar;
  logic [10:0]   w_sum;
  logic [6:0]    w_tile_x_nxt;
  logic [6:0]    w_tile_y_nxt;
  logic [RW-1:0] w_r;
  logic [GW-1:0] w_g;
  logic [BW-1:0] w_b;
  assign w_x = bus.in_pixelx;
  assign w_y = bus.in_pixely;
  assign w_in_range = (32'(w_x) < H_ACTIVE) && (32'(w_y) < V_ACTIVE);
  // cursor tile bounds by shifting, so no multiplier is inferred
  assign w_cx0 = 17'(r_tile_x) << TILE_LOG2;
  assign w_cx1 = (17'(r_tile_x) + 17'd1) << TILE_LOG2;
  assign w_cy0 = 17'(r_tile_y) << TILE_LOG2;
  assign w_cy1 = (17'(r_tile_y) + 17'd1) << TILE_LOG2;
  assign w_cursor = (17'(w_x) >= w_cx0) && (17'(w_x) < w_cx1) &&
                    (17'(w_y) >= w_cy0) && (17'(w_y) < w_cy1);
  assign w_bar_raw = w_x >> BAR_LOG2;
  assign w_bar = (w_bar_raw > 10'd7) ? 3'd7 : w_bar_raw[2:0];
  assign w_sum = 11'(w_x) + 11'(w_y);
  assign w_grid = ((w_x & T_MASK) == '0) || ((w_y & T_MASK) == '0) ||
                  (32'(w_x) == H_ACTIVE - 1) || (32'(w_y) == V_ACTIVE - 1);
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (bus.in_de && w_in_range)
      case (r_mode)
        2'd0: begin
          w_r = w_cursor ? '1 : ((w_x[TILE_LOG2] ^ w_y[TILE_LOG2]) ? R_HALF : '0);
          w_g = (w_x[TILE_LOG2+1] ^ w_y[TILE_LOG2+1]) ? G_HALF : '0;
          w_b = (w_x[TILE_LOG2+2] ^ w_y[TILE_LOG2+2]) ? B_HALF : '0;
        end
        // bar order white,yellow,cyan,green,magenta,red,blue,black maps to inverted index bits
        2'd1: begin
          w_r = {RW{~w_bar[1]}};
          w_g = {GW{~w_bar[2]}};
          w_b = {BW{~w_bar[0]}};
        end
        2'd2: begin
          w_r = RW'(w_x >> 3);
          w_g = GW'(w_y >> 2);
          w_b = BW'(w_sum >> 4);
        end
        default: begin
          w_r = {RW{w_grid}};
          w_g = {GW{w_grid}};
          w_b = {BW{w_grid}};
        end
      endcase
  end
  assign w_step = r_presc == 8'(CURSOR_DIV - 1);
  assign w_last_x = r_tile_x == 7'(TILES_X - 1);
  assign w_tile_x_nxt = w_last_x ? '0 : r_tile_x + 7'd1;
  assign w_tile_y_nxt = !w_last_x ? r_tile_y : (r_tile_y == 7'(TILES_Y - 1)) ? '0 : r_tile_y + 7'd1;
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_mode        <= '0;
      r_presc       <= '0;
      r_tile_x      <= '0;
      r_tile_y      <= '0;
      r_frame_count <= '0;
      r_r           <= '0;
      r_g           <= '0;
      r_b           <= '0;
    end else begin
      r_r <= w_r;
      r_g <= w_g;
      r_b <= w_b;
      if (bus.in_frame_start) begin
        r_frame_count <= r_frame_count + 16'd1;
        r_mode        <= bus.in_mode;
        r_presc       <= w_step ? '0 : r_presc + 8'd1;
        if (w_step) begin
          r_tile_x <= w_tile_x_nxt;
          r_tile_y <= w_tile_y_nxt;
        end
      end
    end
  end
  assign bus.out_r           = r_r;
  assign bus.out_g           = r_g;
  assign bus.out_b           = r_b;
  assign bus.out_tile_x      = r_tile_x;
  assign bus.out_tile_y      = r_tile_y;
  assign bus.out_frame_count = r_frame_count;
endmodule
